// File: rtl/rca32_pkg.sv
// Shared definitions for the 32-bit registered ripple-carry adder.
package rca32_pkg;
    localparam int RCA32_W = 32;
    typedef logic [RCA32_W-1:0] rca32_word_t;
endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell; the adder is built by chaining these carry-to-carry.
module rca_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
    end
endmodule

// File: rtl/rca32_reg_adder.sv
// 32-bit ripple-carry adder with a one-cycle registered output stage.
// Define RCA32_OVF_EN to add the registered signed-overflow output 'ovf'.
module rca32_reg_adder
    import rca32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  rca32_word_t a,
    input  rca32_word_t b,
    input  logic        cin,
    output logic        out_valid,
    output rca32_word_t sum,
    output logic        ca
`ifdef RCA32_OVF_EN
    ,
    output logic        ovf
`endif
);
    // c[i] is the carry into bit i; c[RCA32_W] is the carry-out.
    logic [RCA32_W:0]   c;
    rca32_word_t        s_core;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < RCA32_W; i++) begin : g_fa
            rca_full_adder u_fa (
                .x  (a[i]),
                .y  (b[i]),
                .ci (c[i]),
                .s  (s_core[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    rca32_word_t sum_d, sum_q;
    logic        ca_d, ca_q;
    logic        out_valid_d, out_valid_q;
`ifdef RCA32_OVF_EN
    logic        ovf_d, ovf_q;
`endif

    // Load the core result on a valid cycle, otherwise hold; valid tracks in_valid.
    always_comb begin
        sum_d       = sum_q;
        ca_d        = ca_q;
        out_valid_d = in_valid;
`ifdef RCA32_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (in_valid) begin
            sum_d = s_core;
            ca_d  = c[RCA32_W];
`ifdef RCA32_OVF_EN
            // Signed overflow: carry into the sign bit differs from carry out of it.
            ovf_d = c[RCA32_W] ^ c[RCA32_W-1];
`endif
        end
    end

    // Output register stage, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            ca_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef RCA32_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            ca_q        <= ca_d;
            out_valid_q <= out_valid_d;
`ifdef RCA32_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign ca        = ca_q;
    assign out_valid = out_valid_q;
`ifdef RCA32_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_rca32_reg_adder.sv
// Directed and random bench for rca32_reg_adder using an expected-result queue.
module tb_rca32_reg_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic [31:0] sum;
    logic        ca;
`ifdef RCA32_OVF_EN
    logic        ovf;
`endif

    rca32_reg_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .ca        (ca)
`ifdef RCA32_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        ca;
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    // reference model state (register contents the DUT should hold)
    logic        m_v   = 1'b0;
    logic        m_ca  = 1'b0;
    logic [31:0] m_sum = '0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge),
    // queue the expectation, then check one time unit after the rising edge.
    task automatic drive(input string tag, input logic v, input logic [31:0] ta,
                         input logic [31:0] tb_, input logic tcin);
        logic [32:0] full;
        exp_t        e;
        in_valid = v;
        a        = ta;
        b        = tb_;
        cin      = tcin;
        full = {1'b0, ta} + {1'b0, tb_} + {32'b0, tcin};
        if (v) begin
            m_sum = full[31:0];
            m_ca  = full[32];
            m_ovf = full[32] ^ (ta[31] ^ tb_[31] ^ full[31]);
        end
        m_v = v;
        sb.push_back('{m_v, m_ca, m_sum, m_ovf});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, {32'b0, out_valid}, {32'b0, e.v});
        chk({tag, ".sum_ca"}, {ca, sum}, {e.ca, e.sum});
`ifdef RCA32_OVF_EN
        chk({tag, ".ovf"}, {32'b0, ovf}, {32'b0, e.ovf});
`endif
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_sum_ca"}, {ca, sum}, 33'd0);
        chk({tag, ".rst_valid"}, {32'b0, out_valid}, 33'd0);
`ifdef RCA32_OVF_EN
        chk({tag, ".rst_ovf"}, {32'b0, ovf}, 33'd0);
`endif
        m_v = 1'b0; m_ca = 1'b0; m_sum = '0; m_ovf = 1'b0;
        sb.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        cin      = 1'b1;
        #2;
        chk("reset.sum_ca", {ca, sum}, 33'd0);
        chk("reset.valid", {32'b0, out_valid}, 33'd0);
`ifdef RCA32_OVF_EN
        chk("reset.ovf", {32'b0, ovf}, 33'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        drive("zero",      1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        drive("max_nc",    1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        drive("max_c",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drive("ripple1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive("ripple2",   1'b1, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1);
        drive("five3",     1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0);
        drive("hold1",     1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        drive("hold2",     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drive("ovf_pos",   1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive("ovf_neg",   1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        drive("cin_only",  1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        reset_pulse("midrst");
        drive("after_rst", 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 499) == 0)
                reset_pulse("rand_rst");
            drive("rand", ($urandom_range(0, 7) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
